add_accum: RTL and testbench
============================

Name: add_accum

Overview:
- Sequential accumulator stage that sits directly downstream of the 4-bit adder datapath.
- Consumes a stream of WIDTH-bit sums over a valid/ready handshake and adds COUNT consecutive beats into a wider register.
- Presents each frame total, with a sticky overflow flag, on a valid/ready output handshake.
- Acts as the frame-summing back end for the adder demo datapath.

Parameters:
- WIDTH, 4, width of each input beat.
- COUNT, 4, beats per frame; legal range 1..255.
- ACC_WIDTH, 6, accumulator and output width; must be >= WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active low.
- clear  input  1  synchronous frame abort, active high.
- in_valid  input  1  in_data carries a beat.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  WIDTH  unsigned beat value, typically adder {co,s} or s.
- out_valid  output  1  out_sum and out_ovf hold a completed frame.
- out_ready  input  1  downstream takes the frame this cycle.
- out_sum  output  ACC_WIDTH  frame total modulo 2^ACC_WIDTH.
- out_ovf  output  1  set if any addition in the frame carried out of ACC_WIDTH.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=ACCUM; acc=0; cnt=0; ovf=0.
  - out_valid=0; out_sum=0; out_ovf=0.
  - in_ready reads 1 once rst_n is high.
- States: ACCUM (collecting beats) and HOLD (frame presented).
- Beat accept is in_valid && in_ready. Output handshake is out_valid && out_ready.
- ACCUM:
  - in_ready=1, out_valid=0.
  - On accept: {carry, acc} <= acc + zero-extended in_data; ovf <= ovf | carry; cnt <= cnt+1.
  - On the accept where cnt==COUNT-1: out_sum <= the new total; out_ovf <= the new ovf; state -> HOLD.
  - out_valid rises the cycle after the last beat is accepted (1-cycle latency).
- HOLD:
  - out_valid=1; in_ready=out_ready (combinational). No beat is accepted while the frame is unconsumed.
  - out_sum and out_ovf stay stable while out_valid && !out_ready.
  - Handshake with no beat accepted: acc=0, cnt=0, ovf=0, state -> ACCUM.
  - Handshake with a beat accepted in the same cycle: that beat starts the next frame. acc <= in_data, cnt <= 1, ovf <= 0.
    - If COUNT==1, the block stays in HOLD and out_sum <= in_data for the new frame.
    - Otherwise state -> ACCUM.
- COUNT==1: every accepted beat completes a frame. Full throughput holds with out_ready tied high.
- Counter: cnt is clog2(COUNT+1) bits and never exceeds COUNT-1 in ACCUM. It wraps to 0 (or 1, per the HOLD rule) at frame end.
- Arithmetic: unsigned only. The sum is truncated to ACC_WIDTH bits. out_ovf is sticky within a frame and cleared at the start of each frame.
- clear:
  - Overrides every other event in its cycle: acc=0, cnt=0, ovf=0, out_valid=0, state -> ACCUM.
  - A concurrent beat or output handshake is discarded.
  - out_sum and out_ovf values are don't-care after clear but must not change while out_valid=1.
- rst_n asserted mid-frame or in HOLD aborts immediately to the reset values; no partial frame is emitted.
- in_data is don't-care when in_valid=0. The block never samples it without in_valid.

Test Plan:
- Defaults, beats 3,5,7,9 back-to-back, out_ready=1 -> out_valid one cycle after beat 9; out_sum=24; out_ovf=0; in_ready=1 the next cycle.
- Defaults, four beats of 15 -> out_sum=60, out_ovf=0. Same with ACC_WIDTH=5 -> out_sum=28, out_ovf=1. Next frame 1,1,1,1 -> out_sum=4, out_ovf=0 (flag cleared).
- Frame completes with out_ready=0 for 3 cycles, in_valid=1 with data 6 -> out_sum holds; in_ready=0; no beat accepted. Cycle out_ready=1 -> handshake plus beat 6 accepted; next frame 6,1,1,1 -> out_sum=9.
- Two beats 4,4 accepted, then clear=1 with in_valid=1 data 7 -> beat discarded; next beats 1,2,3,4 -> out_sum=10.
- rst_n low mid-frame after beats 2,2, or during HOLD -> all outputs 0 immediately. After release, beats 1,1,1,1 -> out_sum=4.
- COUNT=1, in_valid and out_ready held 1, beats 5,9,2 -> out_valid stays high; out_sum=5,9,2 on consecutive cycles.

Source files
------------

// File: rtl/add_accum.sv
// Frame accumulator behind the adder datapath: sums COUNT beats into an
// ACC_WIDTH register and presents each total with a sticky overflow flag.
module add_accum #(
    parameter int WIDTH     = 4,
    parameter int COUNT     = 4,
    parameter int ACC_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_ovf
);

    localparam int CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 sumOvf_q, sumOvf_d;

    logic                 accept;
    logic                 handshake;
    logic [ACC_WIDTH:0]   dataExt;
    logic [ACC_WIDTH:0]   addFull;

    // One spare bit above the accumulator captures the carry-out of each add.
    assign dataExt   = {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, in_data};
    assign addFull   = {1'b0, acc_q} + dataExt;

    assign in_ready  = (state_q == ACCUM) ? 1'b1 : out_ready;
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;
    assign out_sum   = sum_q;
    assign out_ovf   = sumOvf_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        sum_d    = sum_q;
        sumOvf_d = sumOvf_q;

        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_d = addFull[ACC_WIDTH-1:0];
                        ovf_d = ovf_q | addFull[ACC_WIDTH];
                        if (cnt_q == LAST_CNT) begin
                            cnt_d    = '0;
                            sum_d    = addFull[ACC_WIDTH-1:0];
                            sumOvf_d = ovf_q | addFull[ACC_WIDTH];
                            state_d  = HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // A beat taken alongside the handshake opens the next frame.
                    if (handshake) begin
                        if (accept) begin
                            acc_d = dataExt[ACC_WIDTH-1:0];
                            ovf_d = 1'b0;
                            if (COUNT == 1) begin
                                cnt_d    = '0;
                                sum_d    = dataExt[ACC_WIDTH-1:0];
                                sumOvf_d = 1'b0;
                            end else begin
                                cnt_d   = CNT_W'(1);
                                state_d = ACCUM;
                            end
                        end else begin
                            acc_d   = '0;
                            cnt_d   = '0;
                            ovf_d   = 1'b0;
                            state_d = ACCUM;
                        end
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACCUM;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            sum_q    <= '0;
            sumOvf_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            sum_q    <= sum_d;
            sumOvf_q <= sumOvf_d;
        end
    end

endmodule

// File: tb/tb_add_accum.sv
// Scoreboard bench for add_accum: default, narrow-accumulator and
// single-beat-frame instances, each with its own expected-frame queue.
module tb_add_accum;

    logic clk = 1'b0;
    logic rst_n;

    logic       clr0, iv0, ir0, ov0, ordy0, oo0;
    logic [3:0] id0;
    logic [5:0] os0;

    logic       clr1, iv1, ir1, ov1, ordy1, oo1;
    logic [3:0] id1;
    logic [4:0] os1;

    logic       clr2, iv2, ir2, ov2, ordy2, oo2;
    logic [3:0] id2;
    logic [5:0] os2;

    int checks = 0;
    int errors = 0;

    // Expected frames packed as ovf*256 + sum.
    int sb0[$];
    int sb1[$];
    int sb2[$];

    always #5 clk = ~clk;

    add_accum #(.WIDTH(4), .COUNT(4), .ACC_WIDTH(6)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clr0),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(ordy0), .out_sum(os0), .out_ovf(oo0)
    );

    add_accum #(.WIDTH(4), .COUNT(4), .ACC_WIDTH(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clr1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(ordy1), .out_sum(os1), .out_ovf(oo1)
    );

    add_accum #(.WIDTH(4), .COUNT(1), .ACC_WIDTH(6)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clr2),
        .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(ordy2), .out_sum(os2), .out_ovf(oo2)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int which, input int data);
        case (which)
            0: begin iv0 = 1'b1; id0 = 4'(data); end
            1: begin iv1 = 1'b1; id1 = 4'(data); end
            default: begin iv2 = 1'b1; id2 = 4'(data); end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors pop one expected frame per output handshake.
    always @(negedge clk) begin
        if (rst_n && ov0 && ordy0) begin
            if (sb0.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL sb0_extra_frame actual=%0d expected=none", int'(os0));
            end else
                checkOutput("sb0_frame", int'(oo0) * 256 + int'(os0), sb0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov1 && ordy1) begin
            if (sb1.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL sb1_extra_frame actual=%0d expected=none", int'(os1));
            end else
                checkOutput("sb1_frame", int'(oo1) * 256 + int'(os1), sb1.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov2 && ordy2) begin
            if (sb2.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL sb2_extra_frame actual=%0d expected=none", int'(os2));
            end else
                checkOutput("sb2_frame", int'(oo2) * 256 + int'(os2), sb2.pop_front());
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        {clr0, iv0, ordy0, clr1, iv1, ordy1, clr2, iv2, ordy2} = '0;
        id0 = '0; id1 = '0; id2 = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", int'(ov0), 0);
        checkOutput("rst_sum", int'(os0), 0);
        checkOutput("rst_ovf", int'(oo0), 0);
        checkOutput("rst_valid_count1", int'(ov2), 0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_inready", int'(ir0), 1);

        // Basic frame, no overflow.
        ordy0 = 1'b1;
        sb0.push_back(24);
        applyStimulus(0, 3); applyStimulus(0, 5);
        applyStimulus(0, 7); applyStimulus(0, 9);
        iv0 = 1'b0;
        checkOutput("t1_valid_latency", int'(ov0), 1);
        tick();
        checkOutput("t1_inready_after", int'(ir0), 1);
        checkOutput("t1_valid_drop", int'(ov0), 0);

        sb0.push_back(60);
        for (int i = 0; i < 4; i++) applyStimulus(0, 15);
        iv0 = 1'b0;
        tick();

        // Stalled output must hold the frame and refuse beats.
        ordy0 = 1'b0;
        sb0.push_back(8);
        for (int i = 0; i < 4; i++) applyStimulus(0, 2);
        id0 = 4'd6;
        for (int i = 0; i < 3; i++) begin
            checkOutput("t3_stall_inready", int'(ir0), 0);
            checkOutput("t3_stall_sum", int'(os0), 8);
            checkOutput("t3_stall_valid", int'(ov0), 1);
            tick();
        end
        ordy0 = 1'b1;
        sb0.push_back(9);
        tick();
        for (int i = 0; i < 3; i++) applyStimulus(0, 1);
        iv0 = 1'b0;
        tick();

        // Clear discards the partial frame and its concurrent beat.
        applyStimulus(0, 4); applyStimulus(0, 4);
        clr0 = 1'b1; id0 = 4'd7;
        tick();
        clr0 = 1'b0;
        checkOutput("t4_clear_valid", int'(ov0), 0);
        sb0.push_back(10);
        applyStimulus(0, 1); applyStimulus(0, 2);
        applyStimulus(0, 3); applyStimulus(0, 4);
        iv0 = 1'b0;
        tick();

        // Narrow accumulator: sticky overflow, then cleared for the next frame.
        ordy1 = 1'b1;
        sb1.push_back(256 + 28);
        sb1.push_back(4);
        for (int i = 0; i < 4; i++) applyStimulus(1, 15);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1);
        iv1 = 1'b0;
        checkOutput("t5_inready_hold", int'(ir1), 1);
        tick();

        // Single-beat frames stream at full rate.
        ordy2 = 1'b1;
        sb2.push_back(5); sb2.push_back(9); sb2.push_back(2);
        applyStimulus(2, 5);
        checkOutput("t6_sum_a", int'(os2), 5);
        checkOutput("t6_valid_a", int'(ov2), 1);
        applyStimulus(2, 9);
        checkOutput("t6_sum_b", int'(os2), 9);
        checkOutput("t6_inready", int'(ir2), 1);
        applyStimulus(2, 2);
        checkOutput("t6_sum_c", int'(os2), 2);
        checkOutput("t6_valid_c", int'(ov2), 1);
        iv2 = 1'b0;
        tick();
        checkOutput("t6_valid_drop", int'(ov2), 0);

        // Reset mid-frame.
        applyStimulus(0, 2); applyStimulus(0, 2);
        iv0 = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("t7_mid_valid", int'(ov0), 0);
        checkOutput("t7_mid_sum", int'(os0), 0);
        checkOutput("t7_mid_ovf", int'(oo0), 0);
        tick();
        rst_n = 1'b1;
        sb0.push_back(4);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1);
        iv0 = 1'b0;
        tick();

        // Reset while a frame is held.
        ordy0 = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(0, 3);
        iv0 = 1'b0;
        checkOutput("t8_hold_valid", int'(ov0), 1);
        checkOutput("t8_hold_sum", int'(os0), 12);
        rst_n = 1'b0;
        #1;
        checkOutput("t8_rst_valid", int'(ov0), 0);
        checkOutput("t8_rst_sum", int'(os0), 0);
        tick();
        rst_n = 1'b1;
        ordy0 = 1'b1;
        repeat (3) tick();

        checkOutput("sb0_drained", sb0.size(), 0);
        checkOutput("sb1_drained", sb1.size(), 0);
        checkOutput("sb2_drained", sb2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
